// File: rtl/spi_device_tx_if.sv
// Transmit-side bundle between the device data path and the SPI transmit shifter.
// The master drives words and control; the slave (shifter) returns the handshake and pad data.
interface spi_device_tx_if;
    logic        en_quad_in;
    logic [7:0]  counter_in;
    logic        counter_in_upd;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic        sdo0;
    logic        sdo1;
    logic        sdo2;
    logic        sdo3;
    logic        tx_done;

    modport master (
        output en_quad_in, counter_in, counter_in_upd, data, data_valid,
        input  data_ready, sdo0, sdo1, sdo2, sdo3, tx_done
    );

    modport slave (
        input  en_quad_in, counter_in, counter_in_upd, data, data_valid,
        output data_ready, sdo0, sdo1, sdo2, sdo3, tx_done
    );
endinterface

// File: rtl/spi_device_tx.sv
// SPI device transmit shifter: 32-bit words go out MSB-first in single or quad mode on falling sclk,
// with a one-word holding buffer for gap-free back-to-back words; cs high holds everything in reset.
module spi_device_tx (
    input  logic              sclk,
    input  logic              cs,
    spi_device_tx_if.slave    bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned NIB_W  = 4;
    localparam logic [CNT_W-1:0] TARGET_RST = CNT_W'(31);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e             r_state;
    logic [WORD_W-1:0]  r_shift;
    logic [CNT_W-1:0]   r_counter;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_target_pend;
    logic [WORD_W-1:0]  r_buf;
    logic               r_buf_full;
    logic               r_armed;

    logic               w_running;
    logic               w_last;
    logic               w_load_now;
    logic               w_ready;
    logic [NIB_W-1:0]   w_nib;
    logic [WORD_W-1:0]  w_shift_next;

    assign w_running  = (r_state == ST_SHIFT);
    assign w_last     = w_running && (r_counter == r_target);
    assign w_load_now = r_armed && r_buf_full && (!w_running || w_last);
    // cs gating keeps the handshake quiet while deselected
    assign w_ready    = !cs && bus.data_valid && (!r_buf_full || w_load_now);

    assign w_shift_next = bus.en_quad_in ? {r_shift[WORD_W-NIB_W-1:0], NIB_W'(0)}
                                         : {r_shift[WORD_W-2:0], 1'b0};

    assign w_nib = !w_running       ? NIB_W'(0) :
                   bus.en_quad_in   ? r_shift[WORD_W-1 -: NIB_W] :
                                      {3'b000, r_shift[WORD_W-1]};

    assign bus.data_ready = w_ready;
    assign bus.tx_done    = w_last;
    assign bus.sdo0       = w_nib[0];
    assign bus.sdo1       = w_nib[1];
    assign bus.sdo2       = w_nib[2];
    assign bus.sdo3       = w_nib[3];

    always_ff @(negedge sclk or posedge cs) begin
        if (cs) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_counter     <= '0;
            r_target      <= TARGET_RST;
            r_target_pend <= TARGET_RST;
            r_buf         <= '0;
            r_buf_full    <= 1'b0;
            r_armed       <= 1'b0;
        end else begin
            // an accept on a reload edge refills the buffer the reload just emptied
            if (w_ready) begin
                r_buf      <= bus.data;
                r_buf_full <= 1'b1;
            end else if (w_load_now) begin
                r_buf_full <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_load_now) begin
                        r_shift   <= r_buf;
                        r_target  <= r_target_pend;
                        r_counter <= '0;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_load_now) begin
                        r_shift   <= r_buf;
                        r_target  <= r_target_pend;
                        r_counter <= '0;
                    end else if (w_last) begin
                        r_state   <= ST_IDLE;
                        r_armed   <= 1'b0;
                        r_shift   <= '0;
                    end else begin
                        r_shift   <= w_shift_next;
                        r_counter <= r_counter + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // a fresh arm request outranks the end-of-word disarm on the same edge
            if (bus.counter_in_upd) begin
                r_armed       <= 1'b1;
                r_target_pend <= bus.counter_in;
            end
        end
    end
endmodule

// File: tb/tb_spi_device_tx.sv
// Self-checking bench for spi_device_tx: random words against a per-bit-time stream model.
module tb_spi_device_tx;
    logic sclk;
    logic cs;
    int   n_pass;
    int   n_total;

    spi_device_tx_if bus ();

    spi_device_tx dut (
        .sclk (sclk),
        .cs   (cs),
        .bus  (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Expected {tx_done, sdo3..sdo0} during bit-time k of a word with target t.
    function automatic logic [4:0] exp_out(input logic [31:0] w, input bit q, input int t, input int k);
        logic [3:0] nib;
        nib = 4'h0;
        if (q) begin
            if (k <= 7) nib = w[31-4*k -: 4];
        end else begin
            if (k <= 31) nib = {3'b000, w[31-k]};
        end
        return {1'(k == t), nib};
    endfunction

    function automatic logic [4:0] obs();
        return {bus.tx_done, bus.sdo3, bus.sdo2, bus.sdo1, bus.sdo0};
    endfunction

    task automatic tick();
        @(negedge sclk);
        @(posedge sclk);
        #1;
    endtask

    task automatic do_reset();
        cs = 1'b1;
        bus.en_quad_in = 1'b0;
        bus.counter_in = 8'd0;
        bus.counter_in_upd = 1'b0;
        bus.data = 32'h0;
        bus.data_valid = 1'b0;
        tick();
        cs = 1'b0;
    endtask

    task automatic test_reset();
        cs = 1'b1;
        bus.data = $urandom;
        bus.data_valid = 1'b1;
        bus.counter_in_upd = 1'b1;
        bus.counter_in = 8'd31;
        #1;
        n_total++;
        if (obs() !== 5'h0) $display("FAIL reset_out: got %h exp 00", obs()); else n_pass++;
        n_total++;
        if (bus.data_ready !== 1'b0) $display("FAIL reset_ready: got %b exp 0", bus.data_ready); else n_pass++;
        tick();
        tick();
        n_total++;
        if (obs() !== 5'h0) $display("FAIL reset_hold_out: got %h exp 00", obs()); else n_pass++;
        do_reset();
        tick();
        n_total++;
        if (obs() !== 5'h0) $display("FAIL reset_idle_out: got %h exp 00", obs()); else n_pass++;
    endtask

    task automatic test_single(input logic [31:0] w, input int t);
        do_reset();
        bus.data = w;
        bus.data_valid = 1'b1;
        #1;
        n_total++;
        if (bus.data_ready !== 1'b1) $display("FAIL single_accept: got %b exp 1", bus.data_ready); else n_pass++;
        tick();
        bus.data_valid = 1'b0;
        bus.counter_in = 8'(t);
        bus.counter_in_upd = 1'b1;
        #1;
        n_total++;
        if (obs() !== 5'h0) $display("FAIL single_unarmed: got %h exp 00", obs()); else n_pass++;
        tick();
        bus.counter_in_upd = 1'b0;
        #1;
        n_total++;
        if (obs() !== 5'h0) $display("FAIL single_prelaunch: got %h exp 00", obs()); else n_pass++;
        tick();
        for (int k = 0; k <= t; k++) begin
            #1;
            n_total++;
            if (obs() !== exp_out(w, 1'b0, t, k))
                $display("FAIL single_bit k=%0d: got %h exp %h", k, obs(), exp_out(w, 1'b0, t, k));
            else n_pass++;
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            n_total++;
            if (obs() !== 5'h0) $display("FAIL single_after: got %h exp 00", obs()); else n_pass++;
            tick();
        end
    endtask

    task automatic test_quad(input logic [31:0] w, input int t);
        do_reset();
        bus.en_quad_in = 1'b1;
        bus.counter_in = 8'(t);
        bus.counter_in_upd = 1'b1;
        tick();
        bus.counter_in_upd = 1'b0;
        bus.data = w;
        bus.data_valid = 1'b1;
        #1;
        n_total++;
        if (bus.data_ready !== 1'b1) $display("FAIL quad_accept: got %b exp 1", bus.data_ready); else n_pass++;
        tick();
        bus.data_valid = 1'b0;
        #1;
        n_total++;
        if (obs() !== 5'h0) $display("FAIL quad_prelaunch: got %h exp 00", obs()); else n_pass++;
        tick();
        for (int k = 0; k <= t; k++) begin
            #1;
            n_total++;
            if (obs() !== exp_out(w, 1'b1, t, k))
                $display("FAIL quad_nibble k=%0d: got %h exp %h", k, obs(), exp_out(w, 1'b1, t, k));
            else n_pass++;
            tick();
        end
        #1;
        n_total++;
        if (obs() !== 5'h0) $display("FAIL quad_after: got %h exp 00", obs()); else n_pass++;
        bus.en_quad_in = 1'b0;
    endtask

    task automatic test_back_to_back(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic [31:0] words [3];
        words[0] = w0; words[1] = w1; words[2] = w2;
        do_reset();
        bus.counter_in = 8'd31;
        bus.counter_in_upd = 1'b1;
        bus.data = w0;
        bus.data_valid = 1'b1;
        tick();
        bus.counter_in_upd = 1'b0;
        bus.data_valid = 1'b0;
        tick();
        for (int t = 0; t < 96; t++) begin
            if (t == 3) begin bus.data = w1; bus.data_valid = 1'b1; end
            else if (t == 4) begin bus.data = w2; bus.data_valid = 1'b1; end
            else if (t == 32) bus.data_valid = 1'b0;
            #1;
            n_total++;
            if (obs() !== exp_out(words[t/32], 1'b0, 31, t%32))
                $display("FAIL b2b_bit t=%0d: got %h exp %h", t, obs(), exp_out(words[t/32], 1'b0, 31, t%32));
            else n_pass++;
            if (t >= 3 && t <= 31) begin
                n_total++;
                if (bus.data_ready !== 1'((t == 3) || (t == 31)))
                    $display("FAIL b2b_ready t=%0d: got %b exp %b", t, bus.data_ready, (t == 3) || (t == 31));
                else n_pass++;
            end
            tick();
        end
        #1;
        n_total++;
        if (obs() !== 5'h0) $display("FAIL b2b_after: got %h exp 00", obs()); else n_pass++;
    endtask

    task automatic test_underrun(input logic [31:0] w0, input logic [31:0] w);
        do_reset();
        bus.counter_in = 8'd31;
        bus.counter_in_upd = 1'b1;
        bus.data = w0;
        bus.data_valid = 1'b1;
        tick();
        bus.counter_in_upd = 1'b0;
        bus.data_valid = 1'b0;
        tick();
        for (int k = 0; k < 32; k++) begin
            #1;
            n_total++;
            if (obs() !== exp_out(w0, 1'b0, 31, k))
                $display("FAIL under_first k=%0d: got %h exp %h", k, obs(), exp_out(w0, 1'b0, 31, k));
            else n_pass++;
            tick();
        end
        bus.data = w;
        bus.data_valid = 1'b1;
        #1;
        n_total++;
        if (bus.data_ready !== 1'b1) $display("FAIL under_accept: got %b exp 1", bus.data_ready); else n_pass++;
        tick();
        bus.data_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++;
            if (obs() !== 5'h0) $display("FAIL under_idle i=%0d: got %h exp 00", i, obs()); else n_pass++;
            tick();
        end
        bus.counter_in_upd = 1'b1;
        tick();
        bus.counter_in_upd = 1'b0;
        #1;
        n_total++;
        if (obs() !== 5'h0) $display("FAIL under_armedge: got %h exp 00", obs()); else n_pass++;
        tick();
        for (int k = 0; k < 32; k++) begin
            #1;
            n_total++;
            if (obs() !== exp_out(w, 1'b0, 31, k))
                $display("FAIL under_rearm k=%0d: got %h exp %h", k, obs(), exp_out(w, 1'b0, 31, k));
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_pending(input logic [31:0] a, input logic [31:0] b);
        do_reset();
        bus.counter_in = 8'd31;
        bus.counter_in_upd = 1'b1;
        bus.data = a;
        bus.data_valid = 1'b1;
        tick();
        bus.counter_in_upd = 1'b0;
        bus.data_valid = 1'b0;
        tick();
        for (int k = 0; k < 32; k++) begin
            bus.counter_in_upd = 1'(k == 10);
            bus.data_valid = 1'(k == 10);
            bus.counter_in = 8'd7;
            bus.data = b;
            #1;
            n_total++;
            if (obs() !== exp_out(a, 1'b0, 31, k))
                $display("FAIL pend_a k=%0d: got %h exp %h", k, obs(), exp_out(a, 1'b0, 31, k));
            else n_pass++;
            tick();
        end
        bus.counter_in_upd = 1'b0;
        bus.data_valid = 1'b0;
        bus.en_quad_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_total++;
            if (obs() !== exp_out(b, 1'b1, 7, k))
                $display("FAIL pend_b k=%0d: got %h exp %h", k, obs(), exp_out(b, 1'b1, 7, k));
            else n_pass++;
            tick();
        end
        #1;
        n_total++;
        if (obs() !== 5'h0) $display("FAIL pend_after: got %h exp 00", obs()); else n_pass++;
        bus.en_quad_in = 1'b0;
    endtask

    task automatic test_reset_mid(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        do_reset();
        bus.counter_in = 8'd31;
        bus.counter_in_upd = 1'b1;
        bus.data = a;
        bus.data_valid = 1'b1;
        tick();
        bus.counter_in_upd = 1'b0;
        bus.data_valid = 1'b0;
        tick();
        for (int k = 0; k <= 10; k++) begin
            bus.data = b;
            bus.data_valid = 1'(k == 2);
            #1;
            n_total++;
            if (obs() !== exp_out(a, 1'b0, 31, k))
                $display("FAIL mid_a k=%0d: got %h exp %h", k, obs(), exp_out(a, 1'b0, 31, k));
            else n_pass++;
            if (k < 10) tick();
        end
        bus.data = c;
        bus.data_valid = 1'b1;
        cs = 1'b1;
        #1;
        n_total++;
        if (obs() !== 5'h0) $display("FAIL mid_abort_out: got %h exp 00", obs()); else n_pass++;
        n_total++;
        if (bus.data_ready !== 1'b0) $display("FAIL mid_abort_ready: got %b exp 0", bus.data_ready); else n_pass++;
        tick();
        tick();
        cs = 1'b0;
        bus.data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (obs() !== 5'h0) $display("FAIL mid_quiet i=%0d: got %h exp 00", i, obs()); else n_pass++;
            tick();
        end
        bus.counter_in_upd = 1'b1;
        tick();
        bus.counter_in_upd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (obs() !== 5'h0) $display("FAIL mid_bufgone i=%0d: got %h exp 00", i, obs()); else n_pass++;
            tick();
        end
        bus.data = c;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        tick();
        for (int k = 0; k < 32; k++) begin
            #1;
            n_total++;
            if (obs() !== exp_out(c, 1'b0, 31, k))
                $display("FAIL mid_c k=%0d: got %h exp %h", k, obs(), exp_out(c, 1'b0, 31, k));
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        cs = 1'b1;
        bus.en_quad_in = 1'b0;
        bus.counter_in = 8'd0;
        bus.counter_in_upd = 1'b0;
        bus.data = 32'h0;
        bus.data_valid = 1'b0;
        @(posedge sclk);
        #1;
        test_reset();
        test_single(32'hA5A50F0F, 31);
        test_single($urandom, 31);
        test_single($urandom, 32 + int'($urandom_range(0, 3)));
        test_quad(32'h12345678, 7);
        test_quad($urandom, 7);
        test_quad($urandom, 8 + int'($urandom_range(0, 4)));
        test_back_to_back(32'hFFFF0000, 32'h0000FFFF, $urandom);
        test_back_to_back($urandom, $urandom, $urandom);
        test_underrun($urandom, 32'hDEADBEEF);
        test_pending($urandom, $urandom);
        test_reset_mid($urandom, $urandom, $urandom);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
